// File: rtl/pipelined_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry add/sub unit.
package pipelined_rca_pkg;

    // Opcode encoding on in_sub
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Number of pipeline stages: one stage per SEG_W-bit segment
    function automatic int calc_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/pipelined_rca_segment.sv
// Combinational SEG_W-bit ripple-carry adder slice used once per pipeline stage.
module rca_segment
    import pipelined_rca_pkg::*;
#(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [SEG_W:0] c;

    // Bit-serial carry chain through the slice
    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[SEG_W];
    // Carry into the slice MSB; only meaningful for overflow in the top slice
    assign cmsb = c[SEG_W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Segmented, pipelined ripple-carry adder/subtractor with valid/ready flow control.
// Each stage resolves one SEG_W-bit segment and passes the carry, the partial
// sum and the full operands to the next stage; the last stage drives the outputs.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    if ((SEG_W < 1) || (WIDTH % SEG_W != 0)) begin : g_bad_params
        $error("pipelined_rca: WIDTH must be a positive multiple of SEG_W");
    end

    // Per-stage state gathered into packed arrays so neighbours can read it
    logic [NSEG-1:0]            vld_pipe;
    logic [NSEG-1:0]            cry_pipe;
    logic [NSEG-1:0]            ovf_pipe;
    logic [NSEG-1:0][WIDTH-1:0] a_pipe;
    logic [NSEG-1:0][WIDTH-1:0] b_pipe;
    logic [NSEG-1:0][WIDTH-1:0] s_pipe;
    logic [NSEG:0]              rdy;

    // Subtract is A + ~B + ~borrow
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    assign b_eff = (in_sub == SUB) ? ~in_b : in_b;
    assign c_eff = (in_sub == SUB) ? ~in_cin : in_cin;

    // Backpressure: a stage accepts if empty or if its successor accepts
    always_comb begin
        rdy       = '0;
        rdy[NSEG] = out_ready;
        for (int k = NSEG - 1; k >= 0; k--) begin
            rdy[k] = ~vld_pipe[k] | rdy[k + 1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [WIDTH-1:0] src_a, src_b, src_s, s_nxt;
        logic             src_v, src_c;
        logic [SEG_W-1:0] seg_s;
        logic             seg_co, seg_cm;
        logic             v_r, c_r, o_r;
        logic [WIDTH-1:0] a_r, b_r, s_r;

        if (k == 0) begin : g_first
            assign src_v = in_valid;
            assign src_a = in_a;
            assign src_b = b_eff;
            assign src_s = '0;
            assign src_c = c_eff;
        end else begin : g_next
            assign src_v = vld_pipe[k-1];
            assign src_a = a_pipe[k-1];
            assign src_b = b_pipe[k-1];
            assign src_s = s_pipe[k-1];
            assign src_c = cry_pipe[k-1];
        end

        rca_segment #(.SEG_W(SEG_W)) u_seg (
            .a    (src_a[k*SEG_W +: SEG_W]),
            .b    (src_b[k*SEG_W +: SEG_W]),
            .cin  (src_c),
            .sum  (seg_s),
            .cout (seg_co),
            .cmsb (seg_cm)
        );

        // Merge this segment into the partial sum carried down the pipe
        always_comb begin
            s_nxt                      = src_s;
            s_nxt[k*SEG_W +: SEG_W]    = seg_s;
        end

        // Stage register: advances when this stage can accept
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                o_r <= 1'b0;
                a_r <= '0;
                b_r <= '0;
                s_r <= '0;
            end else if (rdy[k]) begin
                v_r <= src_v;
                if (src_v) begin
                    c_r <= seg_co;
                    o_r <= seg_cm ^ seg_co;
                    a_r <= src_a;
                    b_r <= src_b;
                    s_r <= s_nxt;
                end
            end
        end

        assign vld_pipe[k] = v_r;
        assign cry_pipe[k] = c_r;
        assign ovf_pipe[k] = o_r;
        assign a_pipe[k]   = a_r;
        assign b_pipe[k]   = b_r;
        assign s_pipe[k]   = s_r;
    end

    // Operand copies in the last stage and overflow of inner stages are never read
    logic unused_bits;
    assign unused_bits = ^{a_pipe, b_pipe, ovf_pipe};

    assign in_ready  = rst_n & rdy[0];
    assign out_valid = vld_pipe[NSEG-1];
    assign out_sum   = s_pipe[NSEG-1];
    assign out_cout  = cry_pipe[NSEG-1];
    assign out_ovf   = ovf_pipe[NSEG-1];

endmodule
